// File: rtl/if_stage_fetch.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency imem reads,
// and fills the IF/ID register through a one-entry skid buffer.
module if_stage_fetch #(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     INS_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [INS_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  output logic             imem_rd_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [INS_W-1:0] imem_rdata_i,
  output logic             if_id_valid_o,
  output logic [PC_W-1:0]  if_id_pc_o,
  output logic [INS_W-1:0] if_id_instr_o
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             pend_q, pend_d;

  logic             skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INS_W-1:0] skid_instr_q, skid_instr_d;

  logic             ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INS_W-1:0] ifid_instr_q, ifid_instr_d;

  logic             issue;
  logic [PC_W-1:0]  issue_addr;

  // Redirect always fetches; otherwise a stall suppresses the read.
  always_comb begin
    issue      = 1'b0;
    issue_addr = pc_q;
    if (redirect_i) begin
      issue      = 1'b1;
      issue_addr = redirect_pc_i;
    end else if (!stall_i) begin
      issue      = 1'b1;
    end
  end

  assign imem_rd_o   = issue & ~reset;
  assign imem_addr_o = issue_addr;

  always_comb begin
    pc_d     = issue ? issue_addr + PC_W'(4) : pc_q;
    req_pc_d = issue ? issue_addr : req_pc_q;
    pend_d   = issue;
  end

  always_comb begin
    state_d      = state_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (redirect_i) begin
      skid_valid_d = 1'b0;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      state_d      = RUN;
    end else begin
      unique case (state_q)
        BOOT: begin
          if (!stall_i) state_d = RUN;
        end
        RUN: begin
          if (stall_i) begin
            if (pend_q) begin
              skid_valid_d = 1'b1;
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem_rdata_i;
              state_d      = HOLD;
            end
          end else if (pend_q) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = req_pc_q;
            ifid_instr_d = imem_rdata_i;
          end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc_q;
            ifid_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
            state_d      = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      pend_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      pend_q       <= pend_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign if_id_valid_o = ifid_valid_q;
  assign if_id_pc_o    = ifid_pc_q;
  assign if_id_instr_o = ifid_instr_q;

endmodule
